// File: rtl/order_4_1_serial.sv
// Serializer for the 4-input sort stage: accepts one 4-word group per handshake
// and streams it out one word per beat through a two-slot ping-pong buffer.
module order_4_1_serial #(
  parameter int DSIZE   = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] indata0,
  input  logic [DSIZE-1:0] indata1,
  input  logic [DSIZE-1:0] indata2,
  input  logic [DSIZE-1:0] indata3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] outdata,
  output logic [1:0]       out_index,
  output logic             out_last,
  output logic [15:0]      group_cnt
);

  logic [1:0][3:0][DSIZE-1:0] slot;
  logic [1:0] count;
  logic [1:0] beat;
  logic [1:0] sel;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       rdy_q;
  logic       push;
  logic       beat_hs;
  logic       pop;

  // in_ready comes only from registers; rdy_q keeps it low until the first edge after reset
  assign in_ready  = rdy_q && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign beat_hs   = out_valid && out_ready;
  assign pop       = beat_hs && (beat == 2'd3);

  assign sel       = DESCEND ? (2'd3 - beat) : beat;
  // Gated by out_valid so stale or unknown slot contents never reach the port
  assign outdata   = out_valid ? slot[rd_ptr][sel] : '0;
  assign out_index = beat;
  assign out_last  = out_valid && (beat == 2'd3);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      count     <= 2'd0;
      beat      <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rdy_q     <= 1'b0;
      group_cnt <= 16'd0;
    end else begin
      rdy_q <= 1'b1;
      if (push) begin
        slot[wr_ptr] <= {indata3, indata2, indata1, indata0};
        wr_ptr       <= ~wr_ptr;
      end
      if (beat_hs) beat <= beat + 2'd1;
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        group_cnt <= group_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_order_4_1_serial.sv
// Scoreboard bench: ascending and descending instances share stimulus; a negedge
// monitor pops expected words on every output handshake.
module tb_order_4_1_serial;

  logic       clock;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] indata0, indata1, indata2, indata3;

  logic        ir0, ov0, ol0, ir1, ov1, ol1;
  logic [7:0]  od0, od1;
  logic [1:0]  oi0, oi1;
  logic [15:0] gc0, gc1;

  typedef struct {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   gap_en = 0;

  order_4_1_serial #(.DSIZE(8), .DESCEND(1'b0)) dut0 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .indata0(indata0), .indata1(indata1), .indata2(indata2), .indata3(indata3),
    .out_valid(ov0), .out_ready(out_ready), .outdata(od0), .out_index(oi0),
    .out_last(ol0), .group_cnt(gc0));

  order_4_1_serial #(.DSIZE(8), .DESCEND(1'b1)) dut1 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .indata0(indata0), .indata1(indata1), .indata2(indata2), .indata3(indata3),
    .out_valid(ov1), .out_ready(out_ready), .outdata(od1), .out_index(oi1),
    .out_last(ol1), .group_cnt(gc1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: inputs change at posedge+1, so values seen here are the ones the next edge uses
  always @(negedge clock) begin
    if (rst_n === 1'b1) begin
      if (ov0 === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL asc_stray: got word %0d idx %0d, required no word", od0, oi0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if ({od0, oi0, ol0} !== {e.d, e.i, e.l}) begin
            n_fail++;
            $display("FAIL asc_word: got d=%0d i=%0d l=%0b, required d=%0d i=%0d l=%0b",
                     od0, oi0, ol0, e.d, e.i, e.l);
          end
        end
      end
      if (ov1 === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL desc_stray: got word %0d idx %0d, required no word", od1, oi1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if ({od1, oi1, ol1} !== {e.d, e.i, e.l}) begin
            n_fail++;
            $display("FAIL desc_word: got d=%0d i=%0d l=%0b, required d=%0d i=%0d l=%0b",
                     od1, oi1, ol1, e.d, e.i, e.l);
          end
        end
      end
      if (gap_en && q0.size() != 0) begin
        n_cmp++;
        if (ov0 !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_gap: got out_valid=%0b, required 1", ov0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; gap_en = 0;
    indata0 = 'x; indata1 = 'x; indata2 = 'x; indata3 = 'x;
    #1;
    q0.delete(); q1.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_group(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    logic [7:0] w [4];
    int t = 0;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    in_valid = 1'b1; indata0 = a; indata1 = b; indata2 = c; indata3 = d;
    while (ir0 !== 1'b1 && t < 200) begin step(); t++; end
    if (t >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: got in_ready=%0b, required 1 within 200 cycles", ir0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        q0.push_back('{d: w[k],     i: 2'(k), l: (k == 3)});
        q1.push_back('{d: w[3 - k], i: 2'(k), l: (k == 3)});
      end
    end
    step();
    in_valid = 1'b0;
    indata0 = 'x; indata1 = 'x; indata2 = 'x; indata3 = 'x;
  endtask

  task automatic wait_drain(output bit ok);
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin step(); t++; end
    ok = (q0.size() == 0 && q1.size() == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    indata0 = 8'd1; indata1 = 8'd2; indata2 = 8'd3; indata3 = 8'd4;
    #1;
    q0.delete(); q1.delete();
    n_cmp++;
    if ({ov0, od0, oi0, ol0, gc0, ir0} !== {1'b0, 8'd0, 2'd0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%0d i=%0d l=%0b cnt=%0d rdy=%0b, required all 0",
               ov0, od0, oi0, ol0, gc0, ir0);
    end
    repeat (2) step();
    n_cmp++;
    if (ir0 !== 1'b0 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got in_ready=%0b out_valid=%0b, required 0/0", ir0, ov0);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ir0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %0b, required 0", ir0);
    end
    step();
    n_cmp++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_release: got in_ready=%0b out_valid=%0b, required 1/0", ir0, ov0);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit ok;
    reset_dut();
    out_ready = 1'b1;
    push_group(8'd3, 8'd5, 8'd7, 8'd9);
    n_cmp++;
    if ({ov0, od0, oi0, od1, gc0} !== {1'b1, 8'd3, 2'd0, 8'd9, 16'd0}) begin
      n_fail++;
      $display("FAIL single_first: got v=%0b asc=%0d i=%0d desc=%0d cnt=%0d, required 1/3/0/9/0",
               ov0, od0, oi0, od1, gc0);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok || gc0 !== 16'd1 || gc1 !== 16'd1 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got drained=%0b cnt=%0d/%0d v=%0b, required 1, 1/1, 0",
               ok, gc0, gc1, ov0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t = 0;
    reset_dut();
    out_ready = 1'b1;
    push_group(8'd1, 8'd2, 8'd3, 8'd4);
    while (oi0 !== 2'd2 && t < 10) begin step(); t++; end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({ov0, od0, oi0, ol0, od1} !== {1'b1, 8'd3, 2'd2, 1'b0, 8'd2}) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0b asc=%0d i=%0d l=%0b desc=%0d, required 1/3/2/0/2",
                 ov0, od0, oi0, ol0, od1);
      end
    end
    out_ready = 1'b1;
    wait_drain(ok);
    n_cmp++;
    if (!ok || gc0 !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_done: got drained=%0b cnt=%0d, required 1/1", ok, gc0);
    end
  endtask

  task automatic test_full();
    bit ok;
    int t = 0;
    reset_dut();
    out_ready = 1'b0;
    push_group(8'd10, 8'd11, 8'd12, 8'd13);
    n_cmp++;
    if (ir0 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_one_slot: got in_ready=%0b, required 1", ir0);
    end
    push_group(8'd20, 8'd21, 8'd22, 8'd23);
    n_cmp++;
    if (ir0 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_two_slots: got in_ready=%0b, required 0", ir0);
    end
    in_valid = 1'b1;
    indata0 = 8'd30; indata1 = 8'd31; indata2 = 8'd32; indata3 = 8'd33;
    repeat (3) begin
      step();
      n_cmp++;
      if (ir0 !== 1'b0 || ir1 !== 1'b0) begin
        n_fail++;
        $display("FAIL full_blocked: got in_ready=%0b/%0b, required 0/0", ir0, ir1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (ol0 !== 1'b1 && t < 20) begin step(); t++; end
    n_cmp++;
    if (ol0 !== 1'b1 || ir0 !== 1'b0 || od0 !== 8'd13) begin
      n_fail++;
      $display("FAIL full_last_beat: got last=%0b in_ready=%0b d=%0d, required 1/0/13", ol0, ir0, od0);
    end
    step();
    n_cmp++;
    if (ir0 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_return: got in_ready=%0b, required 1", ir0);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok || gc0 !== 16'd2 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: got drained=%0b cnt=%0d v=%0b, required 1/2/0", ok, gc0, ov0);
    end
  endtask

  task automatic test_stream();
    bit ok;
    reset_dut();
    out_ready = 1'b1;
    for (int g = 0; g < 100; g++) begin
      push_group(8'($urandom_range(10, 0)), 8'($urandom_range(10, 0)),
                 8'($urandom_range(10, 0)), 8'($urandom_range(10, 0)));
      gap_en = 1;
    end
    wait_drain(ok);
    gap_en = 0;
    n_cmp++;
    if (!ok || gc0 !== 16'd100 || gc1 !== 16'd100) begin
      n_fail++;
      $display("FAIL stream_count: got drained=%0b cnt=%0d/%0d, required 1, 100/100", ok, gc0, gc1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    out_ready = 1'b1;
    push_group(8'd40, 8'd41, 8'd42, 8'd43);
    push_group(8'd50, 8'd51, 8'd52, 8'd53);
    while (oi0 !== 2'd1 && t < 10) begin step(); t++; end
    n_cmp++;
    if (gc0 !== 16'd100 || ov0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before: got cnt=%0d v=%0b, required 100/1", gc0, ov0);
    end
    #2 rst_n = 1'b0;
    #1;
    q0.delete(); q1.delete();
    n_cmp++;
    if ({ov0, ov1, od0, gc0, ir0} !== {1'b0, 1'b0, 8'd0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b/%0b d=%0d cnt=%0d rdy=%0b, required 0/0/0/0/0",
               ov0, ov1, od0, gc0, ir0);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0 || gc0 !== 16'd0) begin
        n_fail++;
        $display("FAIL mid_stale: got v=%0b/%0b cnt=%0d, required 0/0/0", ov0, ov1, gc0);
      end
    end
    push_group(8'd60, 8'd61, 8'd62, 8'd63);
    wait_drain(ok);
    n_cmp++;
    if (!ok || gc0 !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_recover: got drained=%0b cnt=%0d, required 1/1", ok, gc0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    indata0 = 'x; indata1 = 'x; indata2 = 'x; indata3 = 'x;
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
